// File: rtl/conv_pass_sequencer_if.sv
// SRAM control payload type and the job-control interface of the separable
// blur pass sequencer (request fields in, status pulses out).
package conv_pass_sequencer_pkg;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DIM_W  = 8;
  localparam int unsigned SIG_W  = 3;

  typedef struct packed {
    logic              write_en;
    logic              sense_en;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    logic [DATA_W-1:0] din;
  } img_sram_ctrl_t;
endpackage

interface conv_pass_sequencer_if;
  import conv_pass_sequencer_pkg::*;

  logic             start;
  logic             abort;
  logic             two_pass;
  logic [DIM_W-1:0] nrows;
  logic [DIM_W-1:0] ncols;
  logic [SIG_W-1:0] sigma;
  logic             busy;
  logic             done;
  logic             err;

  modport master (output start, abort, two_pass, nrows, ncols, sigma,
                  input  busy, done, err);
  modport slave  (input  start, abort, two_pass, nrows, ncols, sigma,
                  output busy, done, err);
endinterface

// File: rtl/conv_pass_sequencer.sv
// Runs the row controller once (row blur) or twice (transposed 2D blur) and
// steers the image/buffer SRAM ports between the row controller and the host.
module conv_pass_sequencer
  import conv_pass_sequencer_pkg::*;
#(
  parameter int unsigned MIN_DIM = 6
) (
  input  logic                  clk,
  input  logic                  rstn,
  conv_pass_sequencer_if.slave  job,
  input  img_sram_ctrl_t        host_ctrl,
  input  logic                  host_sel,
  output logic [DATA_W-1:0]     host_dout,
  output img_sram_ctrl_t        img_sram_ctrl,
  input  logic [DATA_W-1:0]     img_sram_dout,
  output img_sram_ctrl_t        buf_sram_ctrl,
  input  logic [DATA_W-1:0]     buf_sram_dout,
  output logic                  conv_rstn,
  output logic [DIM_W-1:0]      conv_nrows,
  output logic [DIM_W-1:0]      conv_ncols,
  output logic [SIG_W-1:0]      conv_sigma,
  output logic                  conv_transpose,
  input  logic                  conv_busy,
  output logic [DATA_W-1:0]     conv_din,
  input  img_sram_ctrl_t        conv_rd_ctrl,
  input  img_sram_ctrl_t        conv_wr_ctrl
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    P1_RST = 3'd1,
    P1_RUN = 3'd2,
    P2_RST = 3'd3,
    P2_RUN = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [DIM_W-1:0] MIN_DIM_V = DIM_W'(MIN_DIM);

  state_t           state, state_n;
  logic             seen_busy;
  logic             two_pass_q;
  logic [DIM_W-1:0] nrows_q, ncols_q;
  logic [SIG_W-1:0] sigma_q;
  logic             busy_q, done_q, err_q;

  logic geom_bad, accept, reject, in_run, pass_end, to_p2;

  assign job.busy = busy_q;
  assign job.done = done_q;
  assign job.err  = err_q;

  // Next-state logic; abort from any busy state overrides the normal flow
  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    reject   = 1'b0;
    geom_bad = (job.ncols < MIN_DIM_V) || (job.nrows == '0) ||
               (job.two_pass && (job.nrows < MIN_DIM_V));
    in_run   = (state == P1_RUN) || (state == P2_RUN);
    pass_end = in_run && seen_busy && !conv_busy;
    case (state)
      IDLE: begin
        if (job.start && !job.abort) begin
          if (geom_bad) begin
            reject = 1'b1;
          end else begin
            accept  = 1'b1;
            state_n = P1_RST;
          end
        end
      end
      P1_RST: state_n = P1_RUN;
      P1_RUN: if (pass_end) state_n = two_pass_q ? P2_RST : DONE;
      P2_RST: state_n = P2_RUN;
      P2_RUN: if (pass_end) state_n = DONE;
      DONE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if ((state != IDLE) && job.abort) state_n = IDLE;
    to_p2 = (state == P1_RUN) && (state_n == P2_RST);
  end

  // State, job latch and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      seen_busy      <= 1'b0;
      two_pass_q     <= 1'b0;
      nrows_q        <= '0;
      ncols_q        <= '0;
      sigma_q        <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      conv_rstn      <= 1'b0;
      conv_nrows     <= '0;
      conv_ncols     <= '0;
      conv_sigma     <= '0;
      conv_transpose <= 1'b0;
    end else begin
      state     <= state_n;
      busy_q    <= (state_n != IDLE);
      done_q    <= (state_n == DONE);
      err_q     <= reject;
      conv_rstn <= (state_n == P1_RUN) || (state_n == P2_RUN);

      if ((state_n == IDLE) || (state_n == P1_RST) || (state_n == P2_RST))
        seen_busy <= 1'b0;
      else if (in_run && conv_busy)
        seen_busy <= 1'b1;

      if (accept) begin
        two_pass_q     <= job.two_pass;
        nrows_q        <= job.nrows;
        ncols_q        <= job.ncols;
        sigma_q        <= job.sigma;
        conv_nrows     <= job.nrows;
        conv_ncols     <= job.ncols;
        conv_sigma     <= job.sigma;
        conv_transpose <= job.two_pass;
      end else if (to_p2) begin
        // Second pass walks the transposed image held in the buffer SRAM
        conv_nrows     <= ncols_q;
        conv_ncols     <= nrows_q;
        conv_sigma     <= sigma_q;
        conv_transpose <= 1'b1;
      end
    end
  end

  // SRAM port steering; host requests only reach an SRAM while idle
  always_comb begin
    img_sram_ctrl = '0;
    buf_sram_ctrl = '0;
    conv_din      = '0;
    case (state)
      IDLE: begin
        if (host_sel) buf_sram_ctrl = host_ctrl;
        else          img_sram_ctrl = host_ctrl;
      end
      P1_RUN: begin
        img_sram_ctrl = conv_rd_ctrl;
        buf_sram_ctrl = conv_wr_ctrl;
        conv_din      = img_sram_dout;
      end
      P2_RUN: begin
        buf_sram_ctrl = conv_rd_ctrl;
        img_sram_ctrl = conv_wr_ctrl;
        conv_din      = buf_sram_dout;
      end
      default: ;
    endcase
  end

  assign host_dout = host_sel ? buf_sram_dout : img_sram_dout;

endmodule

// File: tb/tb_conv_pass_sequencer.sv
// Randomized job sequences against a job-level model of the pass sequencer;
// the row controller is played by the bench through conv_busy and ctrl buses.
module tb_conv_pass_sequencer;
  import conv_pass_sequencer_pkg::*;

  localparam int unsigned MIN_DIM = 6;

  logic clk = 1'b0;
  logic rstn;
  img_sram_ctrl_t host_ctrl, img_sram_ctrl, buf_sram_ctrl, conv_rd_ctrl, conv_wr_ctrl;
  logic        host_sel;
  logic [7:0]  host_dout, img_sram_dout, buf_sram_dout, conv_din;
  logic        conv_rstn, conv_transpose, conv_busy;
  logic [7:0]  conv_nrows, conv_ncols;
  logic [2:0]  conv_sigma;

  int n_checks = 0;
  int n_pass   = 0;

  conv_pass_sequencer_if job_if();

  conv_pass_sequencer #(.MIN_DIM(MIN_DIM)) dut (
    .clk(clk), .rstn(rstn), .job(job_if),
    .host_ctrl(host_ctrl), .host_sel(host_sel), .host_dout(host_dout),
    .img_sram_ctrl(img_sram_ctrl), .img_sram_dout(img_sram_dout),
    .buf_sram_ctrl(buf_sram_ctrl), .buf_sram_dout(buf_sram_dout),
    .conv_rstn(conv_rstn), .conv_nrows(conv_nrows), .conv_ncols(conv_ncols),
    .conv_sigma(conv_sigma), .conv_transpose(conv_transpose),
    .conv_busy(conv_busy), .conv_din(conv_din),
    .conv_rd_ctrl(conv_rd_ctrl), .conv_wr_ctrl(conv_wr_ctrl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit legal(input bit tp, input logic [7:0] nr, input logic [7:0] nc);
    return (int'(nc) >= MIN_DIM) && (nr != 0) && (!tp || int'(nr) >= MIN_DIM);
  endfunction

  function automatic img_sram_ctrl_t rnd_ctrl();
    return img_sram_ctrl_t'(25'($urandom));
  endfunction

  task automatic drive_bus();
    conv_rd_ctrl  = rnd_ctrl();
    conv_wr_ctrl  = rnd_ctrl();
    host_ctrl     = rnd_ctrl();
    host_ctrl.write_en = 1'b1;
    host_sel      = 1'($urandom);
    img_sram_dout = 8'($urandom);
    buf_sram_dout = 8'($urandom);
    #1;
  endtask

  // Host port reaches only the selected SRAM while idle
  task automatic check_idle_steer(input string tag);
    drive_bus();
    if (host_sel) begin
      check({tag, "_buf_host"}, 32'(buf_sram_ctrl), 32'(host_ctrl));
      check({tag, "_img_off"},  32'(img_sram_ctrl), 32'd0);
    end else begin
      check({tag, "_img_host"}, 32'(img_sram_ctrl), 32'(host_ctrl));
      check({tag, "_buf_off"},  32'(buf_sram_ctrl), 32'd0);
    end
    check({tag, "_host_dout"}, 32'(host_dout), 32'(host_sel ? buf_sram_dout : img_sram_dout));
  endtask

  // One job: start, then each pass plays lead idle cycles and blen busy cycles.
  // abort_pass/abort_cyc select a RUN cycle in which abort is raised (0 = none).
  task automatic run_job(input bit tp, input logic [7:0] nr, input logic [7:0] nc,
                         input logic [2:0] sg, input int blen1, input int blen2,
                         input int abort_pass, input int abort_cyc);
    int passes, lead, blen;
    job_if.start = 1'b1; job_if.abort = 1'b0;
    job_if.two_pass = tp; job_if.nrows = nr; job_if.ncols = nc; job_if.sigma = sg;
    step();
    job_if.start = 1'b0;
    job_if.two_pass = 1'($urandom); job_if.nrows = 8'($urandom); job_if.ncols = 8'($urandom);
    job_if.sigma = 3'($urandom);
    if (!legal(tp, nr, nc)) begin
      check("rej_err", 32'(job_if.err), 32'd1);
      check("rej_busy", 32'(job_if.busy), 32'd0);
      check("rej_rstn", 32'(conv_rstn), 32'd0);
      step();
      check("rej_err_pulse", 32'(job_if.err), 32'd0);
      check("rej_rstn2", 32'(conv_rstn), 32'd0);
      return;
    end
    check("p1rst_busy", 32'(job_if.busy), 32'd1);
    check("p1rst_err", 32'(job_if.err), 32'd0);
    check("p1rst_rstn", 32'(conv_rstn), 32'd0);
    check("p1_nrows", 32'(conv_nrows), 32'(nr));
    check("p1_ncols", 32'(conv_ncols), 32'(nc));
    check("p1_sigma", 32'(conv_sigma), 32'(sg));
    check("p1_transpose", 32'(conv_transpose), 32'(tp));
    drive_bus();
    check("p1rst_img_idle", 32'(img_sram_ctrl), 32'd0);
    check("p1rst_buf_idle", 32'(buf_sram_ctrl), 32'd0);
    passes = tp ? 2 : 1;
    for (int p = 1; p <= passes; p++) begin
      step();
      check("run_rstn", 32'(conv_rstn), 32'd1);
      check("run_busy", 32'(job_if.busy), 32'd1);
      lead = $urandom_range(0, 3);
      blen = (p == 1) ? blen1 : blen2;
      for (int c = 0; c < lead + blen; c++) begin
        conv_busy = (c >= lead);
        job_if.start = (p == 1 && c == 0);
        if (job_if.start) job_if.ncols = 8'd1;
        drive_bus();
        if (p == 1) begin
          check("p1_img_rd", 32'(img_sram_ctrl), 32'(conv_rd_ctrl));
          check("p1_buf_wr", 32'(buf_sram_ctrl), 32'(conv_wr_ctrl));
          check("p1_din", 32'(conv_din), 32'(img_sram_dout));
        end else begin
          check("p2_buf_rd", 32'(buf_sram_ctrl), 32'(conv_rd_ctrl));
          check("p2_img_wr", 32'(img_sram_ctrl), 32'(conv_wr_ctrl));
          check("p2_din", 32'(conv_din), 32'(buf_sram_dout));
        end
        check("run_host_dout", 32'(host_dout), 32'(host_sel ? buf_sram_dout : img_sram_dout));
        if (p == abort_pass && c == abort_cyc) begin
          job_if.abort = 1'b1;
          step();
          job_if.abort = 1'b0; job_if.start = 1'b0; conv_busy = 1'b0;
          check("abort_busy", 32'(job_if.busy), 32'd0);
          check("abort_rstn", 32'(conv_rstn), 32'd0);
          check("abort_done", 32'(job_if.done), 32'd0);
          check("abort_err", 32'(job_if.err), 32'd0);
          check_idle_steer("abort_host");
          step();
          check("abort_done_later", 32'(job_if.done), 32'd0);
          return;
        end
        step();
        job_if.start = 1'b0;
        check("run_stay_rstn", 32'(conv_rstn), 32'd1);
        check("run_no_err", 32'(job_if.err), 32'd0);
        check("run_no_done", 32'(job_if.done), 32'd0);
      end
      conv_busy = 1'b0;
      step();
      if (p < passes) begin
        check("p2rst_rstn", 32'(conv_rstn), 32'd0);
        check("p2_nrows", 32'(conv_nrows), 32'(nc));
        check("p2_ncols", 32'(conv_ncols), 32'(nr));
        check("p2_transpose", 32'(conv_transpose), 32'd1);
        check("p2_sigma", 32'(conv_sigma), 32'(sg));
        check("p2rst_busy", 32'(job_if.busy), 32'd1);
        check("p2rst_done", 32'(job_if.done), 32'd0);
        drive_bus();
        check("p2rst_img_idle", 32'(img_sram_ctrl), 32'd0);
        check("p2rst_buf_idle", 32'(buf_sram_ctrl), 32'd0);
      end else begin
        check("done_pulse", 32'(job_if.done), 32'd1);
        check("done_busy", 32'(job_if.busy), 32'd1);
        check("done_rstn", 32'(conv_rstn), 32'd0);
        drive_bus();
        check("done_img_idle", 32'(img_sram_ctrl), 32'd0);
        check("done_buf_idle", 32'(buf_sram_ctrl), 32'd0);
        step();
        check("after_done", 32'(job_if.done), 32'd0);
        check("after_busy", 32'(job_if.busy), 32'd0);
        check_idle_steer("after_host");
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    job_if.start = 1'b0; job_if.abort = 1'b0; job_if.two_pass = 1'b0;
    job_if.nrows = '0; job_if.ncols = '0; job_if.sigma = '0;
    host_ctrl = '0; host_sel = 1'b0; conv_busy = 1'b0;
    conv_rd_ctrl = '0; conv_wr_ctrl = '0; img_sram_dout = '0; buf_sram_dout = '0;
    #23;
    check("rst_busy", 32'(job_if.busy), 32'd0);
    check("rst_rstn", 32'(conv_rstn), 32'd0);
    check("rst_nrows", 32'(conv_nrows), 32'd0);
    check("rst_transpose", 32'(conv_transpose), 32'd0);
    rstn = 1'b1;
    step();
    check_idle_steer("idle");

    // Directed: 8x8 2D, 6x10 row-only, two illegal geometries, late abort in pass 2
    run_job(1'b1, 8'd8, 8'd8, 3'd1, 10, 10, 0, 0);
    run_job(1'b0, 8'd6, 8'd10, 3'd2, 8, 0, 0, 0);
    run_job(1'b0, 8'd8, 8'd5, 3'd1, 4, 4, 0, 0);
    run_job(1'b1, 8'd4, 8'd8, 3'd1, 4, 4, 0, 0);
    run_job(1'b1, 8'd7, 8'd9, 3'd3, 6, 30, 2, 20);

    // start and abort together in IDLE: nothing happens
    job_if.start = 1'b1; job_if.abort = 1'b1;
    job_if.two_pass = 1'b0; job_if.nrows = 8'd8; job_if.ncols = 8'd8;
    step();
    job_if.start = 1'b0; job_if.abort = 1'b0;
    check("sa_busy", 32'(job_if.busy), 32'd0);
    check("sa_err", 32'(job_if.err), 32'd0);
    job_if.start = 1'b1; job_if.abort = 1'b1; job_if.ncols = 8'd2;
    step();
    job_if.start = 1'b0; job_if.abort = 1'b0;
    check("sa_bad_err", 32'(job_if.err), 32'd0);

    // Asynchronous reset in the middle of pass 1
    job_if.start = 1'b1; job_if.two_pass = 1'b1;
    job_if.nrows = 8'd9; job_if.ncols = 8'd7; job_if.sigma = 3'd5;
    step();
    job_if.start = 1'b0;
    step();
    conv_busy = 1'b1;
    step(); step();
    #2 rstn = 1'b0;
    #1;
    check("arst_busy", 32'(job_if.busy), 32'd0);
    check("arst_rstn", 32'(conv_rstn), 32'd0);
    check("arst_nrows", 32'(conv_nrows), 32'd0);
    check("arst_ncols", 32'(conv_ncols), 32'd0);
    check("arst_sigma", 32'(conv_sigma), 32'd0);
    check("arst_transpose", 32'(conv_transpose), 32'd0);
    conv_busy = 1'b0;
    step();
    rstn = 1'b1;
    step();
    run_job(1'b1, 8'd6, 8'd6, 3'd0, 5, 5, 0, 0);

    // Random jobs, a fraction of them aborted somewhere in a RUN pass
    for (int j = 0; j < 40; j++) begin
      bit tp;
      int b1, b2, ap, ac;
      tp = 1'($urandom);
      b1 = $urandom_range(1, 12);
      b2 = $urandom_range(1, 12);
      ap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, tp ? 2 : 1) : 0;
      ac = $urandom_range(0, 8);
      run_job(tp, 8'($urandom_range(0, 12)), 8'($urandom_range(3, 12)),
              3'($urandom), b1, b2, ap, ac);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/conv_pass_sequencer.md
# conv_pass_sequencer

Top-level sequencer for the separable Gaussian blur. It runs `conv_row_controller` once (row-only blur) or twice (full 2D blur) and steers the image SRAM and buffer SRAM ports between the row controller and the host. In two-pass mode, pass 1 blurs rows from the image SRAM into the buffer SRAM, transposed. Pass 2 blurs the transposed rows from the buffer SRAM back into the image SRAM, transposed again, so the image SRAM ends in its original orientation.

## Interface
Parameters:
- MIN_DIM, 6, smallest legal row length seen by the row controller.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request; accepted only in IDLE.
- abort  in  1  stop the job; honoured in any non-IDLE state.
- two_pass  in  1  1 = 2D blur, 0 = row blur only; latched at start.
- nrows  in  8  image rows; latched at start.
- ncols  in  8  image columns; latched at start.
- sigma  in  3  kernel select; latched at start.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse when a job completes.
- err  out  1  one-cycle pulse when start is rejected.
- host_ctrl  in  img_sram_ctrl_t  host access request.
- host_sel  in  1  0 = image SRAM, 1 = buffer SRAM.
- host_dout  out  8  read data from the SRAM chosen by host_sel.
- img_sram_ctrl  out  img_sram_ctrl_t  image SRAM control.
- img_sram_dout  in  8  image SRAM read data.
- buf_sram_ctrl  out  img_sram_ctrl_t  buffer SRAM control.
- buf_sram_dout  in  8  buffer SRAM read data.
- conv_rstn  out  1  row-controller reset and run-enable.
- conv_nrows  out  8  row-controller nrows.
- conv_ncols  out  8  row-controller ncols.
- conv_sigma  out  3  row-controller sigma.
- conv_transpose  out  1  row-controller transpose_to_buf.
- conv_busy  in  1  row-controller busy.
- conv_din  out  8  row-controller sram_img_dout_in.
- conv_rd_ctrl  in  img_sram_ctrl_t  row-controller sram_img_ctrl (read side).
- conv_wr_ctrl  in  img_sram_ctrl_t  row-controller sram_buf_ctrl (write side).

## Operation
- FSM states: IDLE, P1_RST, P1_RUN, P2_RST, P2_RUN, DONE.
- IDLE:
  - start with abort=0 and illegal geometry pulses err; the state stays IDLE.
  - Illegal geometry is any of: ncols<MIN_DIM, nrows==0, or (two_pass && nrows<MIN_DIM).
  - Otherwise latch the job inputs and go to P1_RST.
  - start and abort in the same cycle: abort wins; nothing is latched and err stays 0.
- P1_RST:
  - conv_rstn=0 for exactly one cycle, then go to P1_RUN.
  - conv_nrows/conv_ncols = latched nrows/ncols.
  - conv_transpose = latched two_pass.
- P1_RUN:
  - conv_rstn=1.
  - A seen_busy flag sets on conv_busy=1.
  - seen_busy && !conv_busy ends the pass: go to P2_RST if two_pass, otherwise DONE.
- P2_RST / P2_RUN: same as pass 1, except:
  - conv_nrows = latched ncols and conv_ncols = latched nrows.
  - conv_transpose = 1.
  - seen_busy is cleared on entry.
  - The end of the pass goes to DONE.
- DONE: done=1 for one cycle, then IDLE.
- abort in any non-IDLE state: next state IDLE, conv_rstn=0 next cycle, no done, no err.
- SRAM steering:
  - IDLE: host_ctrl goes to the SRAM chosen by host_sel. The other SRAM gets write_en=0, sense_en=0, row/col/din=0.
  - P1_RUN: img_sram_ctrl=conv_rd_ctrl; buf_sram_ctrl=conv_wr_ctrl; conv_din=img_sram_dout.
  - P2_RUN: buf_sram_ctrl=conv_rd_ctrl; img_sram_ctrl=conv_wr_ctrl; conv_din=buf_sram_dout.
  - P*_RST and DONE: both SRAMs idle (write_en=0, sense_en=0).
  - Host requests outside IDLE are dropped silently and never reach either SRAM.
- host_dout is a combinational mux on host_sel at all times. The host holds host_sel stable across the one-cycle SRAM read latency.

## Timing
- Reset values:
  - busy=0, done=0, err=0, conv_rstn=0, conv_transpose=0.
  - conv_nrows/conv_ncols/conv_sigma=0.
  - State IDLE; latched job fields 0.
- conv_rstn is a flop output. rstn low forces it low asynchronously. Its deassertion is synchronous to clk.
- Timeline for an accepted start sampled at edge T:
  - busy=1 from T+1 and stays 1 until DONE exits.
  - P1_RST occupies T+1 to T+2; conv_rstn rises at T+2.
- Pass end:
  - The row controller drops conv_busy one cycle after its final write.
  - The sequencer leaves RUN on the edge that samples conv_busy=0, so the final write has already completed.
- done:
  - Asserted in the cycle after the last pass's RUN exits.
  - busy falls together with done's deassertion: busy=0 in the cycle after the done cycle.
- Pass length: roughly nrows·(ncols+5)+2 cycles. The sequencer imposes no timeout.
- A start during busy is ignored and produces no err.

## Test plan
- 8x8 ramp image, sigma=1, two_pass=1:
  - Pass 2 shows conv_nrows=8, conv_ncols=8 and conv_transpose=1.
  - done pulses once and the image SRAM matches the golden 2D blur.
  - No buffer SRAM writes occur in pass 2.
- 6x10 image, two_pass=0:
  - One pass only, conv_transpose=0.
  - The buffer SRAM equals the golden row blur; done follows pass 1 exit by one cycle.
- start with ncols=5, then with two_pass=1 and nrows=4:
  - err pulses for 1 cycle each time; conv_rstn stays 0; busy stays 0.
- abort 20 cycles into P2_RUN:
  - Next cycle is IDLE with conv_rstn=0; no done; the host can read the buffer SRAM immediately.
- Host writes to the image SRAM while in P1_RUN:
  - No host write reaches the image SRAM; image contents are unchanged apart from row-controller traffic.
- rstn pulsed low mid P1_RUN:
  - All outputs return to their reset values asynchronously; a subsequent start runs a full clean job.
